// File: rtl/rr_dec_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_dec_arbiter_pkg
//  Description : Shared state encoding and requester count for the
//                round-robin decoder-form arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_dec_arbiter_pkg;

    // Number of requesters sharing the downstream resource
    localparam int NREQ = 4;

    // Arbiter state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage : rr_dec_arbiter_pkg
`default_nettype wire

// File: rtl/rr_dec_arbiter_dec_case.sv
`default_nettype none
// ============================================================================
//  Module      : dec_case
//  Description : 2-to-4 decoder with enable. Y is one-hot on A when E=1,
//                all zeros when E=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec_case (
    input  logic [1:0] A,
    input  logic       E,
    output logic [3:0] Y
);

    // Decode the index into a one-hot vector, gated by the enable
    always_comb begin
        Y = 4'b0000;
        if (E) begin
            case (A)
                2'd0: Y = 4'b0001;
                2'd1: Y = 4'b0010;
                2'd2: Y = 4'b0100;
                2'd3: Y = 4'b1000;
            endcase
        end
    end

endmodule : dec_case
`default_nettype wire

// File: rtl/rr_dec_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_dec_arbiter
//  Description : Four-way round-robin arbiter with a hold timer. Presents the
//                owner as index + valid (decoder A/E form) and as a one-hot
//                grant produced by the shared dec_case decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_dec_arbiter
    import rr_dec_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [1:0]      gnt_idx,
    output logic            gnt_vld,
    output logic [NREQ-1:0] gnt
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    // Saturation value of the hold counter and the count at which a
    // timeout fires (only meaningful when HOLD_MAX > 0)
    localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0);

    state_t          state,    state_nxt;
    logic [IW-1:0]   owner,    owner_nxt;
    logic [IW-1:0]   ptr,      ptr_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;

    logic [NREQ-1:0] others;
    logic [IW-1:0]   winner_all;
    logic [IW-1:0]   winner_oth;
    logic [IW-1:0]   winner;
    logic            timeout;
    logic            grant_new;

    // First set bit of r scanning p, p+1, p+2, p+3 (mod NREQ)
    function automatic logic [IW-1:0] first_in_order(
        input logic [NREQ-1:0] r,
        input logic [IW-1:0]   p
    );
        logic [IW-1:0] idx;
        logic          found;
        first_in_order = p;
        found          = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = p + IW'(k);
            if (!found && r[idx]) begin
                first_in_order = idx;
                found          = 1'b1;
            end
        end
    endfunction

    // State register: owner, pointer and hold timer, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state logic: arbitrate from idle, hold, release or time out
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        hold_nxt   = hold_cnt;
        grant_new  = 1'b0;

        // The current owner never wins a round it is leaving
        others     = req & ~(NREQ'(1) << owner);
        winner_all = first_in_order(req, ptr);
        winner_oth = first_in_order(others, ptr);
        winner     = winner_all;

        // >= so a saturated counter still yields once a competitor appears
        timeout    = (HOLD_MAX > 0) && (hold_cnt >= HOLD_LAST) && (|others);

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_new = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req[owner] || timeout) begin
                    if (|others) begin
                        grant_new = 1'b1;
                        winner    = winner_oth;
                    end else begin
                        state_nxt = ST_IDLE;
                        hold_nxt  = '0;
                    end
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end
        endcase

        if (grant_new) begin
            state_nxt = ST_GRANT;
            owner_nxt = winner;
            ptr_nxt   = winner + 1'b1;
            hold_nxt  = '0;
        end
    end

    // Output logic: index and valid come straight from registers
    always_comb begin
        gnt_vld = (state == ST_GRANT);
        gnt_idx = owner;
    end

    dec_case u_dec (
        .A (gnt_idx),
        .E (gnt_vld),
        .Y (gnt)
    );

endmodule : rr_dec_arbiter
`default_nettype wire

// File: tb/tb_rr_dec_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_dec_arbiter
//  Description : Self-checking bench for rr_dec_arbiter (HOLD_MAX = 4).
//                Each driven cycle pushes its expected grant into a
//                scoreboard queue; the entry is popped after the edge and
//                compared against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_dec_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic [3:0] gnt;

    int checks;
    int errors;

    typedef struct {
        string      tag;
        logic       in_reset;
        logic [3:0] gnt;
    } exp_t;

    exp_t sb_q[$];

    rr_dec_arbiter #(
        .HOLD_MAX (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare
    task automatic step(input string tag, input logic rn, input logic [3:0] r, input logic [3:0] eg);
        exp_t e;
        rst_n = rn;
        req   = r;
        sb_q.push_back('{tag: tag, in_reset: ~rn, gnt: eg});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".gnt"}, {4'h0, gnt}, {4'h0, e.gnt});
        check({e.tag, ".vld"}, {7'h0, gnt_vld}, {7'h0, |e.gnt});
        if (e.in_reset)
            check({e.tag, ".idx_rst"}, {6'h0, gnt_idx}, 8'h00);
        else if (e.gnt != 4'b0000)
            check({e.tag, ".idx"}, {6'h0, gnt_idx}, {6'h0, onehot_idx(e.gnt)});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        @(posedge clk);
        #1;

        // Reset held with all requests active; first grant is requester 0
        step("rst0", 1'b0, 4'b1111, 4'b0000);
        step("rst1", 1'b0, 4'b1111, 4'b0000);
        step("rst_first", 1'b1, 4'b1111, 4'b0001);
        step("rst_rel", 1'b1, 4'b0000, 4'b0000);

        // Single request and release
        step("single", 1'b1, 4'b0100, 4'b0100);
        step("single_hold", 1'b1, 4'b0100, 4'b0100);
        step("single_rel", 1'b1, 4'b0000, 4'b0000);

        // Fair rotation: each owner drops its bit after 3 cycles of grant
        step("rot_rst", 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) step("rot_o0", 1'b1, 4'b1111, 4'b0001);
        step("rot_o1", 1'b1, 4'b1110, 4'b0010);
        for (int i = 0; i < 2; i++) step("rot_o1h", 1'b1, 4'b1111, 4'b0010);
        step("rot_o2", 1'b1, 4'b1101, 4'b0100);
        for (int i = 0; i < 2; i++) step("rot_o2h", 1'b1, 4'b1111, 4'b0100);
        step("rot_o3", 1'b1, 4'b1011, 4'b1000);
        for (int i = 0; i < 2; i++) step("rot_o3h", 1'b1, 4'b1111, 4'b1000);
        step("rot_wrap", 1'b1, 4'b0111, 4'b0001);
        step("rot_end", 1'b1, 4'b0000, 4'b0000);

        // Timeout: owner 1 holds exactly 4 cycles, then requester 3 wins
        step("to_rst", 1'b0, 4'b0000, 4'b0000);
        step("to_own", 1'b1, 4'b0010, 4'b0010);
        for (int i = 0; i < 3; i++) step("to_hold", 1'b1, 4'b1010, 4'b0010);
        step("to_switch", 1'b1, 4'b1010, 4'b1000);
        step("to_o3h", 1'b1, 4'b1010, 4'b1000);
        step("to_regrant", 1'b1, 4'b0010, 4'b0010);
        step("to_end", 1'b1, 4'b0000, 4'b0000);

        // No contention: a lone requester is never timed out
        for (int i = 0; i < 20; i++) step("nocont", 1'b1, 4'b0100, 4'b0100);
        step("nocont_rel", 1'b1, 4'b0000, 4'b0000);

        // Owner drops its request on the timeout edge: same next winner
        step("tr_rst", 1'b0, 4'b0000, 4'b0000);
        step("tr_own", 1'b1, 4'b0010, 4'b0010);
        for (int i = 0; i < 3; i++) step("tr_hold", 1'b1, 4'b1010, 4'b0010);
        step("tr_drop", 1'b1, 4'b1000, 4'b1000);
        step("tr_end", 1'b1, 4'b0000, 4'b0000);

        // Mid-grant reset clears outputs and the pointer
        step("mr_own", 1'b1, 4'b0100, 4'b0100);
        step("mr_own1", 1'b1, 4'b0010, 4'b0010);
        step("mr_rst", 1'b0, 4'b0010, 4'b0000);
        step("mr_first", 1'b1, 4'b0110, 4'b0010);
        step("mr_hold", 1'b1, 4'b0110, 4'b0010);
        step("mr_next", 1'b1, 4'b0100, 4'b0100);
        step("mr_end", 1'b1, 4'b0000, 4'b0000);

        check("sb_empty", 8'(sb_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_dec_arbiter
`default_nettype wire

// File: doc/rr_dec_arbiter.md
# rr_dec_arbiter

Round-robin arbiter that shares one downstream resource among four requesters. It emits the granted requester both as a 2-bit index with a valid/enable bit, in the same A/E form the 2-to-4 decoder consumes, and as a one-hot grant vector. A hold timer stops one requester from monopolising the resource. It sits between the requester blocks and the shared datapath select logic.

## Interface
Parameters:
- HOLD_MAX, default 15: maximum consecutive cycles one owner may hold the grant while others wait. 0 disables the timeout.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- req  input  4  request vector, bit i = requester i. Level-sensitive, held while the requester wants or uses the resource.
- gnt_idx  output  2  index of the current owner. Drives decoder A.
- gnt_vld  output  1  a grant is active. Drives decoder E.
- gnt  output  4  one-hot grant, equal to decode(gnt_idx) gated by gnt_vld. 4'b0000 when gnt_vld=0.

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: gnt_vld=1; owner = gnt_idx.
- Round-robin pointer ptr[1:0] names the highest-priority candidate. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- Each new grant sets ptr = winner+1 (mod 4) and clears hold_cnt.
- IDLE → GRANT when any req bit is 1; the winner is the first set bit in search order.
- In GRANT, the grant is kept while req[owner]=1 and no timeout fires. hold_cnt increments each cycle and saturates at HOLD_MAX.
- Release: req[owner]=0.
  - If any other req bit is 1, re-arbitrate directly with no idle cycle and stay in GRANT.
  - Otherwise go to IDLE.
- Timeout, only when HOLD_MAX>0: fires when hold_cnt == HOLD_MAX-1 and some req bit other than the owner's is 1. The grant moves to the next winner in search order, and the old owner cannot win this round. If no other request is pending, the owner keeps the grant and hold_cnt stays saturated.
- A preempted owner that is still requesting competes normally in later rounds.
- Requests that rise while the grant is held only enter the next arbitration.
- All outputs are registered. There is no combinational path from req to any output.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, ptr=0, hold_cnt=0, gnt_idx=2'b00, gnt_vld=0, gnt=4'b0000. This applies immediately on that edge and overrides any grant in progress.
- Latency: req sampled at edge n → gnt valid after edge n. One cycle from request to grant.
- Release: req[owner] low sampled at edge n → the new grant, or gnt_vld=0, is visible after edge n.
- Under timeout, the owner holds for exactly HOLD_MAX consecutive cycles before switching.
- If the owner drops req on the same edge the timeout would fire, it is treated as a release. The result is identical: the next winner in search order.
- If all four requests rise together from reset, grant order is 0,1,2,3,0,… as each owner releases or times out.
- hold_cnt width is $clog2(HOLD_MAX+1), minimum 1 bit.

## Structure
- Shared package: state encoding (ST_IDLE, ST_GRANT) and the requester count constant NREQ=4.
- Sub-module: the existing decoder dec_case, instantiated with A=gnt_idx and E=gnt_vld to produce gnt. The arbiter holds the sequential logic; gnt stays consistent with the decoder by construction.
- The priority search is a small combinational function inside the arbiter, not a separate module.

## Test plan
- Reset check: hold rst_n=0 for 2 cycles with req=4'b1111 → gnt_vld=0, gnt=0000, gnt_idx=00 throughout. After rst_n=1, gnt=0001 one cycle later.
- Single request and release: req=0100 → gnt=0100, gnt_idx=10 one cycle later. Drop req → gnt_vld=0 next cycle.
- Fair rotation: req=1111, each owner drops its bit for one cycle after 3 cycles of grant → grant order 0001, 0010, 0100, 1000, 0001.
- Timeout, HOLD_MAX=4: req[1] held high and req[3] rises → owner 1 keeps gnt=0010 for exactly 4 cycles, then gnt=1000. Owner 1 is re-granted after owner 3 releases.
- No contention: HOLD_MAX=4, only req[2] high for 20 cycles → gnt=0100 continuously. hold_cnt saturates with no glitch.
- Mid-grant reset: gnt=0010 active, assert rst_n=0 for one cycle → outputs clear on that edge. With req=0110 afterwards, the first grant is 0010, because ptr is back to 0 and bit 1 is the first set bit in search order.
